carrd_wb_arbiter: RTL and testbench

Parametrised writeback stage for the CARRD vector coprocessor. It gathers results from NUM_SRC execution units (VALU, VMUL, VLSU, VSLDU, VRED, …) through per-source valid/ready handshakes and holds each result in a one-entry slot. It grants one slot per cycle under fixed or round-robin priority and drives a registered write port to the vector register file (NUM_LANES × LANE_W) or the scalar register file. Unlike the earlier combinational selector, no result is lost when two units finish in the same cycle.

---
 rtl/carrd_wb_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_carrd_wb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrd_wb_arbiter.sv
// -----------------------------------------------------------------------------
// carrd_wb_arbiter
//
// Writeback stage for the CARRD vector coprocessor. Each of NUM_SRC execution
// units hands its result over a valid/ready handshake into a dedicated
// one-entry slot. One full slot is granted per cycle, using fixed priority
// (lowest index wins) or round-robin. The granted result drives a registered
// write port toward the vector RF (full NUM_LANES x LANE_W data) or the scalar
// RF (lane 0, low XLEN bits, zero-extended). A result can only leave through a
// grant, so two units finishing in the same cycle never lose a result.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   src_valid[i]   source i offers a result
//   src_ready[i]   slot i accepts this cycle (empty, or retiring this cycle)
//   src_data       per-source result, lane 0 in the LSBs
//   src_dest       per-source 2-bit destination: 1 vector, 2 scalar, 0/3 drop
//   src_addr       per-source destination register index
//   src_bcast      replicate lane 0 across all lanes when the slot loads
//   v_reg_wr_en    vector RF write strobe (registered, single cycle)
//   x_reg_wr_en    scalar RF write strobe (registered, single cycle)
//   reg_wr_addr    write index (holds when nothing is written)
//   reg_wr_data    write data, lane 0 in the LSBs (holds when nothing written)
//   wb_pending     registered count of full slots
//   wb_drop        one-cycle pulse when a dest 0/3 result retires
// -----------------------------------------------------------------------------
module carrd_wb_arbiter #(
    parameter int NUM_SRC   = 5,
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 128,
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 5,
    parameter int RR_MODE   = 0,
    localparam int DATA_W   = NUM_LANES * LANE_W,
    localparam int CNT_W    = $clog2(NUM_SRC + 1),
    localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC*NUM_LANES*LANE_W-1:0] src_data,
    input  logic [NUM_SRC*2-1:0]                src_dest,
    input  logic [NUM_SRC*ADDR_W-1:0]           src_addr,
    input  logic [NUM_SRC-1:0]                  src_bcast,
    output logic                                v_reg_wr_en,
    output logic                                x_reg_wr_en,
    output logic [ADDR_W-1:0]                   reg_wr_addr,
    output logic [NUM_LANES*LANE_W-1:0]         reg_wr_data,
    output logic [CNT_W-1:0]                    wb_pending,
    output logic                                wb_drop
);

    localparam logic [1:0] DEST_VEC = 2'd1;
    localparam logic [1:0] DEST_SCL = 2'd2;

    // ------------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] full_reg;
    logic [NUM_SRC-1:0] full_next;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] grant_vec;
    logic [DATA_W-1:0]  data_reg  [NUM_SRC];
    logic [DATA_W-1:0]  load_data [NUM_SRC];
    logic [1:0]         dest_reg  [NUM_SRC];
    logic [ADDR_W-1:0]  addr_reg  [NUM_SRC];

    // Arbitration state
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [IDX_W:0]     search_sum;
    logic [IDX_W-1:0]   search_idx;

    // Output registers
    logic               v_en_reg;
    logic               x_en_reg;
    logic               drop_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [DATA_W-1:0]  wr_data_reg;
    logic [CNT_W-1:0]   pending_reg;
    logic [CNT_W-1:0]   pending_next;

    logic [DATA_W-1:0]  granted_data;
    logic [1:0]         granted_dest;
    logic [ADDR_W-1:0]  granted_addr;
    logic [DATA_W-1:0]  scalar_data;

    // A slot can take a new beat when empty or when its current occupant
    // retires this very cycle; nothing is accepted while reset is held.
    assign src_ready = rst ? '0 : (~full_reg | grant_vec);
    assign accept    = src_valid & src_ready;

    // ------------------------------------------------------------------
    // Per-slot load path and storage
    // ------------------------------------------------------------------
    genvar gi, gl;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            logic [LANE_W-1:0] lane0;
            assign lane0 = src_data[gi*DATA_W +: LANE_W];

            // Broadcast is resolved at load time so the retire path never
            // needs to know about it.
            for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
                assign load_data[gi][gl*LANE_W +: LANE_W] =
                    src_bcast[gi] ? lane0
                                  : src_data[gi*DATA_W + gl*LANE_W +: LANE_W];
            end

            // Payload fields need no reset: full_reg qualifies them.
            always_ff @(posedge clk) begin
                if (accept[gi]) begin
                    data_reg[gi] <= load_data[gi];
                    dest_reg[gi] <= src_dest[gi*2 +: 2];
                    addr_reg[gi] <= src_addr[gi*ADDR_W +: ADDR_W];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant selection. Fixed mode scans from index 0; round-robin scans
    // from ptr_reg and wraps modulo NUM_SRC.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        search_sum = '0;
        search_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (RR_MODE != 0) begin
                search_sum = {1'b0, ptr_reg} + (IDX_W+1)'(k);
                if (search_sum >= (IDX_W+1)'(NUM_SRC)) begin
                    search_sum = search_sum - (IDX_W+1)'(NUM_SRC);
                end
            end else begin
                search_sum = (IDX_W+1)'(k);
            end
            search_idx = search_sum[IDX_W-1:0];
            if (!grant_any && full_reg[search_idx]) begin
                grant_any = 1'b1;
                grant_idx = search_idx;
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant_vec[i] = grant_any && (grant_idx == IDX_W'(i));
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if ((RR_MODE != 0) && grant_any) begin
            ptr_next = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Accept wins over retire, so a slot that retires and reloads in the
    // same cycle stays full with the new beat.
    always_comb begin
        full_next    = full_reg;
        pending_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                full_next[i] = 1'b1;
            end else if (grant_vec[i]) begin
                full_next[i] = 1'b0;
            end
            pending_next = pending_next + CNT_W'(full_next[i]);
        end
    end

    // ------------------------------------------------------------------
    // Retire path
    // ------------------------------------------------------------------
    assign granted_data = data_reg[grant_idx];
    assign granted_dest = dest_reg[grant_idx];
    assign granted_addr = addr_reg[grant_idx];
    assign scalar_data  = {{(DATA_W - XLEN){1'b0}}, granted_data[XLEN-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg    <= '0;
            ptr_reg     <= '0;
            v_en_reg    <= 1'b0;
            x_en_reg    <= 1'b0;
            drop_reg    <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            pending_reg <= '0;
        end else begin
            full_reg    <= full_next;
            ptr_reg     <= ptr_next;
            pending_reg <= pending_next;
            v_en_reg    <= 1'b0;
            x_en_reg    <= 1'b0;
            drop_reg    <= 1'b0;
            if (grant_any) begin
                case (granted_dest)
                    DEST_VEC: begin
                        v_en_reg    <= 1'b1;
                        wr_addr_reg <= granted_addr;
                        wr_data_reg <= granted_data;
                    end
                    DEST_SCL: begin
                        x_en_reg    <= 1'b1;
                        wr_addr_reg <= granted_addr;
                        wr_data_reg <= scalar_data;
                    end
                    // Discarded results leave the write port untouched.
                    default: drop_reg <= 1'b1;
                endcase
            end
        end
    end

    assign v_reg_wr_en = v_en_reg;
    assign x_reg_wr_en = x_en_reg;
    assign wb_drop     = drop_reg;
    assign reg_wr_addr = wr_addr_reg;
    assign reg_wr_data = wr_data_reg;
    assign wb_pending  = pending_reg;

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_carrd_wb_arbiter
//
// Two instances share one stimulus stream: dut_fx (fixed priority) and
// dut_rr (round-robin). A slot-level reference model per instance predicts
// src_ready every cycle and the registered write port after every edge.
// Directed vectors and hand sequences add explicit expected values.
// -----------------------------------------------------------------------------
module tb_carrd_wb_arbiter;

    localparam int NS = 5;
    localparam int NL = 4;
    localparam int LW = 128;
    localparam int DW = NL * LW;
    localparam int XL = 32;
    localparam int AW = 5;
    localparam int CW = $clog2(NS + 1);

    logic              clk;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS*DW-1:0]  src_data;
    logic [NS*2-1:0]   src_dest;
    logic [NS*AW-1:0]  src_addr;
    logic [NS-1:0]     src_bcast;

    logic [NS-1:0]     ready_f,  ready_r;
    logic              v_f, v_r, x_f, x_r, drop_f, drop_r;
    logic [AW-1:0]     addr_f, addr_r;
    logic [DW-1:0]     data_f, data_r;
    logic [CW-1:0]     pend_f, pend_r;

    carrd_wb_arbiter #(.NUM_SRC(NS), .NUM_LANES(NL), .LANE_W(LW), .XLEN(XL),
                       .ADDR_W(AW), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(ready_f),
        .src_data(src_data), .src_dest(src_dest), .src_addr(src_addr),
        .src_bcast(src_bcast), .v_reg_wr_en(v_f), .x_reg_wr_en(x_f),
        .reg_wr_addr(addr_f), .reg_wr_data(data_f), .wb_pending(pend_f),
        .wb_drop(drop_f));

    carrd_wb_arbiter #(.NUM_SRC(NS), .NUM_LANES(NL), .LANE_W(LW), .XLEN(XL),
                       .ADDR_W(AW), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(ready_r),
        .src_data(src_data), .src_dest(src_dest), .src_addr(src_addr),
        .src_bcast(src_bcast), .v_reg_wr_en(v_r), .x_reg_wr_en(x_r),
        .reg_wr_addr(addr_r), .reg_wr_data(data_r), .wb_pending(pend_r),
        .wb_drop(drop_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, index 0 = fixed priority, 1 = round-robin
    // ------------------------------------------------------------------
    bit            m_full [2][NS];
    logic [DW-1:0] m_data [2][NS];
    logic [1:0]    m_dest [2][NS];
    logic [AW-1:0] m_addr [2][NS];
    int            m_ptr  [2];
    bit            e_v [2], e_x [2], e_drop [2], e_addr_known [2];
    logic [AW-1:0] e_addr [2];
    logic [DW-1:0] e_data [2];
    int            e_pend [2];

    function automatic int pick(input int m);
        for (int k = 0; k < NS; k++) begin
            int i;
            i = (m == 1) ? (m_ptr[m] + k) % NS : k;
            if (m_full[m][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset(input int m);
        for (int i = 0; i < NS; i++) m_full[m][i] = 1'b0;
        m_ptr[m] = 0;
        e_v[m] = 0; e_x[m] = 0; e_drop[m] = 0;
        e_addr[m] = '0; e_data[m] = '0; e_pend[m] = 0;
        e_addr_known[m] = 1;
    endtask

    // One clock: inputs already driven. Check ready, advance the model,
    // cross the edge, check the registered outputs. Returns at posedge+1.
    task automatic cycle();
        #1;
        for (int m = 0; m < 2; m++) begin
            int g;
            logic [NS-1:0] rdy;
            g = rst ? -1 : pick(m);
            for (int i = 0; i < NS; i++) rdy[i] = !rst && (!m_full[m][i] || g == i);
            check(m ? "ready_rr" : "ready_fx", DW'(m ? ready_r : ready_f), DW'(rdy));
            if (rst) begin
                model_reset(m);
            end else begin
                e_v[m] = 0; e_x[m] = 0; e_drop[m] = 0;
                if (g >= 0) begin
                    if (m_dest[m][g] == 2'd1) begin
                        e_v[m] = 1; e_addr[m] = m_addr[m][g]; e_data[m] = m_data[m][g];
                        e_addr_known[m] = 1;
                    end else if (m_dest[m][g] == 2'd2) begin
                        e_x[m] = 1; e_addr[m] = m_addr[m][g];
                        e_data[m] = DW'(m_data[m][g][XL-1:0]);
                        e_addr_known[m] = 1;
                    end else begin
                        e_drop[m] = 1;
                        e_addr_known[m] = 0;
                    end
                    m_full[m][g] = 1'b0;
                    if (m == 1) m_ptr[m] = (g + 1) % NS;
                end
                for (int i = 0; i < NS; i++) begin
                    if (src_valid[i] && rdy[i]) begin
                        logic [LW-1:0] l0;
                        l0 = src_data[i*DW +: LW];
                        m_full[m][i] = 1'b1;
                        m_data[m][i] = src_bcast[i] ? {NL{l0}} : src_data[i*DW +: DW];
                        m_dest[m][i] = src_dest[i*2 +: 2];
                        m_addr[m][i] = src_addr[i*AW +: AW];
                    end
                end
                e_pend[m] = 0;
                for (int i = 0; i < NS; i++) e_pend[m] += int'(m_full[m][i]);
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check(m ? "v_en_rr" : "v_en_fx", DW'(m ? v_r : v_f), DW'(e_v[m]));
            check(m ? "x_en_rr" : "x_en_fx", DW'(m ? x_r : x_f), DW'(e_x[m]));
            check(m ? "drop_rr" : "drop_fx", DW'(m ? drop_r : drop_f), DW'(e_drop[m]));
            check(m ? "pend_rr" : "pend_fx", DW'(m ? pend_r : pend_f), DW'(e_pend[m]));
            check(m ? "data_rr" : "data_fx", m ? data_r : data_f, e_data[m]);
            if (e_addr_known[m])
                check(m ? "addr_rr" : "addr_fx", DW'(m ? addr_r : addr_f), DW'(e_addr[m]));
        end
    endtask

    task automatic set_src(input int i, input logic [1:0] d, input logic [AW-1:0] a,
                           input bit b, input logic [DW-1:0] data);
        src_dest[i*2 +: 2]   = d;
        src_addr[i*AW +: AW] = a;
        src_bcast[i]         = b;
        src_data[i*DW +: DW] = data;
    endtask

    // ------------------------------------------------------------------
    // Directed single-source vectors (applied to the fixed-priority DUT)
    // ------------------------------------------------------------------
    typedef struct {
        int            src;
        logic [1:0]    dest;
        logic [AW-1:0] addr;
        bit            bcast;
        logic [DW-1:0] data;
        bit            ev, ex, ed;
        bit            chka;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [DW-1:0] prev_addr;
        tbl[0] = '{0, 2'd1, 5'd7, 1'b0, {128'd4, 128'd3, 128'd2, 128'd1},
                   1, 0, 0, 1, 5'd7, {128'd4, 128'd3, 128'd2, 128'd1}};
        tbl[1] = '{4, 2'd2, 5'd3, 1'b0,
                   {128'h3, 128'h2, 128'hFFFF_0000, 128'hDEADBEEF_12345678},
                   0, 1, 0, 1, 5'd3, 512'h12345678};
        tbl[2] = '{2, 2'd1, 5'd12, 1'b1, {128'h33, 128'h22, 128'h11, 128'hA5},
                   1, 0, 0, 1, 5'd12, {128'hA5, 128'hA5, 128'hA5, 128'hA5}};
        tbl[3] = '{1, 2'd0, 5'd9, 1'b0, {4{128'h5555}},
                   0, 0, 1, 0, 5'd0, {128'hA5, 128'hA5, 128'hA5, 128'hA5}};
        tbl[4] = '{3, 2'd3, 5'd1, 1'b0, {4{128'h7777}},
                   0, 0, 1, 0, 5'd0, {128'hA5, 128'hA5, 128'hA5, 128'hA5}};
        tbl[5] = '{1, 2'd2, 5'd30, 1'b1, {128'h9, 128'h8, 128'h7, 128'hCAFEF00D_0BADBEEF},
                   0, 1, 0, 1, 5'd30, 512'h0BADBEEF};
        tbl[6] = '{3, 2'd1, 5'd31, 1'b0, {128'hF0, 128'hE0, 128'hD0, 128'hC0},
                   1, 0, 0, 1, 5'd31, {128'hF0, 128'hE0, 128'hD0, 128'hC0}};

        for (int m = 0; m < 2; m++) model_reset(m);
        src_valid = '0; src_data = '0; src_dest = '0; src_addr = '0; src_bcast = '0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset held for two cycles with every source offering
        src_valid = '1;
        for (int i = 0; i < NS; i++) set_src(i, 2'd1, AW'(i), 1'b0, {16{32'h1234_0000 + i}});
        cycle();
        cycle();
        check("reset_v_en", DW'(v_f), '0);
        check("reset_pend", DW'(pend_f), '0);
        check("reset_data", data_f, '0);
        $display("reset: ready=%b pend=%0d", ready_f, pend_f);
        rst = 1'b0;
        src_valid = '0;
        #1;
        check("ready_after_reset", DW'(ready_f), DW'(5'b11111));
        cycle();

        // Directed vectors
        for (int t = 0; t < 7; t++) begin
            set_src(tbl[t].src, tbl[t].dest, tbl[t].addr, tbl[t].bcast, tbl[t].data);
            src_valid = NS'(1) << tbl[t].src;
            cycle();
            check("vec_no_early_strobe", DW'(v_f | x_f | drop_f), '0);
            src_valid = '0;
            cycle();
            check("vec_v_en", DW'(v_f), DW'(tbl[t].ev));
            check("vec_x_en", DW'(x_f), DW'(tbl[t].ex));
            check("vec_drop", DW'(drop_f), DW'(tbl[t].ed));
            check("vec_data", data_f, tbl[t].edata);
            if (tbl[t].chka) check("vec_addr", DW'(addr_f), DW'(tbl[t].eaddr));
            $display("vec %0d: src=%0d dest=%0d -> v=%0b x=%0b drop=%0b addr=%0d",
                     t, tbl[t].src, tbl[t].dest, v_f, x_f, drop_f, addr_f);
        end

        // All sources complete together: fixed order 0..4, pending 4..0
        for (int i = 0; i < NS; i++) set_src(i, 2'd1, AW'(20 + i), 1'b0, {16{32'hABC0_0000 + i}});
        src_valid = '1;
        cycle();
        check("collide_all_full", DW'(pend_f), DW'(NS));
        src_valid = '0;
        for (int k = 0; k < NS; k++) begin
            cycle();
            check("collide_v_en", DW'(v_f), DW'(1'b1));
            check("collide_addr", DW'(addr_f), DW'(20 + k));
            check("collide_pend", DW'(pend_f), DW'(NS - 1 - k));
            $display("collide: write addr=%0d pending=%0d", addr_f, pend_f);
        end
        cycle();

        // Fixed priority starvation: src 0 re-offered every cycle, src 4 waits
        src_valid = 5'b10001;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("starve_addr", DW'(addr_f), DW'(20));
            check("starve_pend", DW'(pend_f), DW'(2));
            $display("starve: write addr=%0d pending=%0d", addr_f, pend_f);
        end
        src_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Round-robin: src 0 and src 3 continuously valid must alternate
        set_src(0, 2'd1, 5'd10, 1'b0, {16{32'h0A0A_0A0A}});
        set_src(3, 2'd1, 5'd13, 1'b0, {16{32'h0D0D_0D0D}});
        src_valid = 5'b01001;
        cycle();
        prev_addr = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_v_en", DW'(v_r), DW'(1'b1));
            check("rr_ready_src0_or_src3", DW'(ready_r[0] | ready_r[3]), DW'(1'b1));
            if (k > 0) begin
                n_cmp++;
                if (DW'(addr_r) == prev_addr) begin
                    n_bad++;
                    $display("FAIL rr_alternate: got addr %0d twice, expected alternation", addr_r);
                end
            end
            prev_addr = DW'(addr_r);
            $display("rr: write addr=%0d", addr_r);
        end
        src_valid = '0;
        for (int k = 0; k < 3; k++) cycle();

        // Reset mid-flight with three slots full
        for (int i = 0; i < 3; i++) set_src(i, 2'd1, AW'(i + 1), 1'b0, {16{32'h6000_0000 + i}});
        src_valid = 5'b00111;
        cycle();
        check("midrst_pend_before", DW'(pend_f), DW'(3));
        src_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("midrst_no_strobe", DW'(v_f | x_f | v_r | x_r), '0);
            check("midrst_pend", DW'(pend_f), '0);
        end
        $display("midflight reset: pending=%0d", pend_f);

        // Randomized traffic checked against the model
        for (int c = 0; c < 600; c++) begin
            src_valid = NS'($urandom);
            for (int w = 0; w < NS * DW / 32; w++) src_data[w*32 +: 32] = $urandom;
            src_dest  = (NS*2)'($urandom);
            src_addr  = (NS*AW)'({$urandom, $urandom});
            for (int i = 0; i < NS; i++) src_bcast[i] = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;
        src_valid = '0;
        for (int k = 0; k < NS + 2; k++) cycle();
        $display("random: 600 cycles done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
